// File: rtl/alu_sequencer_if.sv
// Operand/opcode request and register-file writeback bundle for alu_sequencer.
interface alu_sequencer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 3;

  logic              start;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] operanda;
  logic [DATA_W-1:0] operandb;
  logic              busy;
  logic              done;
  logic              save;
  logic [SEL_W-1:0]  saveselector;
  logic [DATA_W-1:0] savebus;
  logic              zero;
  logic              carry;

  modport master (
    output start, opcode, operanda, operandb,
    input  busy, done, save, saveselector, savebus, zero, carry
  );

  modport slave (
    input  start, opcode, operanda, operandb,
    output busy, done, save, saveselector, savebus, zero, carry
  );
endinterface

// File: rtl/alu_sequencer.sv
// Execution stage: single-cycle ALU ops plus 8-iteration shift/add MUL and
// restoring DIV, written back through the register-file save port.
module alu_sequencer #(
  parameter int unsigned RESULT_REG = 3,
  parameter int unsigned AUX_REG    = 4
) (
  input  logic            clock,
  input  logic            reset,
  alu_sequencer_if.slave  io
);
  localparam int unsigned W     = 8;
  localparam int unsigned OPW   = 3;
  localparam int unsigned SELW  = 3;
  localparam int unsigned CNTW  = 3;
  localparam int unsigned ITERS = 8;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_MUL = 3'b110;
  localparam logic [OPW-1:0] OP_DIV = 3'b111;

  localparam logic [SELW-1:0] SEL_RESULT = SELW'(RESULT_REG);
  localparam logic [SELW-1:0] SEL_AUX    = SELW'(AUX_REG);
  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, ITER, WB_LO, WB_HI} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [W-1:0]    opm_q, opm_d;   // multiplicand (MUL) or divisor (DIV)
  logic [W-1:0]    hi_q, hi_d;     // high product / partial remainder
  logic [W-1:0]    lo_q, lo_d;     // multiplier->low product / dividend->quotient
  logic            flag_q, flag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            save_q, save_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [W-1:0]    bus_q, bus_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;

  logic [W:0]      alu_wide;
  logic [W:0]      mul_sum;
  logic [W:0]      div_sh;
  logic            div_ge;
  logic [W-1:0]    div_diff;
  logic            is_long_q;

  assign is_long_q = op_q[2] & op_q[1];

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opm_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      save_q  <= 1'b0;
      sel_q   <= '0;
      bus_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opm_q   <= opm_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      save_q  <= save_d;
      sel_q   <= sel_d;
      bus_q   <= bus_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opm_d    = opm_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    flag_d   = flag_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    save_d   = 1'b0;
    sel_d    = sel_q;
    bus_d    = bus_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    alu_wide = '0;

    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opm_q : {W{1'b0}})};
    div_sh   = {hi_q, lo_q[W-1]};
    div_ge   = (div_sh >= {1'b0, opm_q});
    div_diff = W'(div_sh - {1'b0, opm_q});

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (io.start) begin
          op_d   = io.opcode;
          busy_d = 1'b1;
          hi_d   = '0;
          cnt_d  = '0;
          if (io.opcode == OP_MUL) begin
            opm_d   = io.operanda;
            lo_d    = io.operandb;
            flag_d  = 1'b0;
            state_d = ITER;
          end else if (io.opcode == OP_DIV) begin
            opm_d   = io.operandb;
            lo_d    = io.operanda;
            flag_d  = (io.operandb == '0);
            state_d = ITER;
          end else begin
            case (io.opcode)
              OP_ADD:  alu_wide = {1'b0, io.operanda} + {1'b0, io.operandb};
              OP_SUB:  alu_wide = {1'b0, io.operanda} - {1'b0, io.operandb};
              OP_AND:  alu_wide = {1'b0, io.operanda & io.operandb};
              OP_OR:   alu_wide = {1'b0, io.operanda | io.operandb};
              OP_XOR:  alu_wide = {1'b0, io.operanda ^ io.operandb};
              default: alu_wide = {1'b0, ~io.operanda};
            endcase
            lo_d    = alu_wide[W-1:0];
            flag_d  = alu_wide[W];
            state_d = WB_LO;
            save_d  = 1'b1;
            sel_d   = SEL_RESULT;
            bus_d   = alu_wide[W-1:0];
            done_d  = 1'b1;
          end
        end
      end

      ITER: begin
        cnt_d = cnt_q + CNTW'(1);
        if (op_q == OP_MUL) begin
          hi_d = mul_sum[W:1];
          lo_d = {mul_sum[0], lo_q[W-1:1]};
        end else begin
          // divide-by-zero naturally yields quotient 0xFF, remainder = dividend
          hi_d = div_ge ? div_diff : div_sh[W-1:0];
          lo_d = {lo_q[W-2:0], div_ge};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = WB_LO;
          save_d  = 1'b1;
          sel_d   = SEL_RESULT;
          bus_d   = lo_d;
        end
      end

      WB_LO: begin
        if (is_long_q) begin
          state_d = WB_HI;
          save_d  = 1'b1;
          sel_d   = SEL_AUX;
          bus_d   = hi_q;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          zero_d  = (lo_q == '0);
          carry_d = flag_q;
        end
      end

      WB_HI: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        zero_d  = (lo_q == '0);
        carry_d = flag_q | ((op_q == OP_MUL) && (hi_q != '0));
      end

      default: state_d = IDLE;
    endcase
  end

  assign io.busy         = busy_q;
  assign io.done         = done_q;
  assign io.save         = save_q;
  assign io.saveselector = sel_q;
  assign io.savebus      = bus_q;
  assign io.zero         = zero_q;
  assign io.carry        = carry_q;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Execution stage downstream of the register file. Consumes the ALU operand pair (reg1/reg2) and an opcode, computes the result, and writes it back through the register file's save port. Single-cycle ops write only the result register. MUL and DIV run an 8-iteration shift/add or restoring-subtract loop and write both a low and a high byte.

Parameters:
RESULT_REG, 3, register-file index receiving the result / low product / quotient
AUX_REG, 4, register-file index receiving the high product / remainder

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  begin operation; sampled only when busy=0
opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MUL, 111 DIV
operanda  input  8  operand A (from reg1)
operandb  input  8  operand B (from reg2)
busy  output  1  operation in progress
done  output  1  one-cycle pulse on the final writeback cycle
save  output  1  register-file write enable
saveselector  output  3  register-file write index
savebus  output  8  register-file write data
zero  output  1  low result byte was 0x00 (last completed op)
carry  output  1  ADD carry-out / SUB borrow / MUL high byte nonzero / DIV divide-by-zero; 0 for logic ops

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, save, zero, carry = 0; saveselector = 0; savebus = 0x00; internal accumulators cleared. Reset mid-operation aborts with no save pulse. First start is accepted on the first rising edge after reset=1.
- All outputs are registered.
- Cycle 0 is the edge that samples start=1 with busy=0. On that edge operanda, operandb and opcode are latched; later input changes do not affect the operation.
- FSM states: IDLE, ITER, WB_LO, WB_HI.
- IDLE -> WB_LO for opcodes 000-101. IDLE -> ITER for 110/111.
- ITER runs exactly 8 cycles (cycles 1-8), one bit per cycle, then goes to WB_LO.
- WB_LO -> IDLE for single-cycle ops. WB_LO -> WB_HI for MUL/DIV. WB_HI -> IDLE.
- Single-cycle op timing:
  - Cycle 1: save=1, saveselector=RESULT_REG, savebus=result, busy=1, done=1.
- MUL/DIV timing:
  - Cycles 1-8: busy=1, save=0.
  - Cycle 9: save=1, saveselector=RESULT_REG, savebus=low byte or quotient.
  - Cycle 10: save=1, saveselector=AUX_REG, savebus=high byte or remainder, done=1.
- busy=1 from cycle 1 through the done cycle inclusive. The next start is accepted on the edge ending the done cycle's successor (busy=0). start while busy=1 is ignored, not queued.
- save is high only in WB states. save, saveselector and savebus are each valid for exactly one cycle per write.
- Arithmetic is unsigned mod 256.
  - ADD: carry = bit 8 of a+b.
  - SUB: a-b, carry = (a<b).
  - NOT A: ~a, operandb ignored.
- MUL: shift-add, 16-bit product; carry = (product[15:8] != 0).
- DIV: restoring, quotient and remainder.
- DIV with b=0: quotient 0xFF, remainder = a, carry=1. Same 10-cycle timing; no early exit.
- zero/carry update on the edge ending the done cycle and hold until the next done. zero reflects the RESULT_REG byte.
- saveselector/savebus hold their last value when save=0 (don't-care for the consumer).

Test Plan:
- Reset release, then start ADD a=200 b=100 -> cycle 1: save=1, saveselector=3, savebus=0x2C, done=1; then carry=1, zero=0.
- SUB a=5 b=7 -> savebus=0xFE, carry=1. SUB a=9 b=9 -> savebus=0x00, zero=1, carry=0.
- MUL a=25 b=12 -> cycles 1-8 save=0 busy=1; cycle 9: reg 3 <= 0x2C; cycle 10: reg 4 <= 0x01, done=1; carry=1.
- DIV a=200 b=7 -> cycle 9: 0x1C to reg 3; cycle 10: 0x04 to reg 4. DIV a=0x55 b=0 -> 0xFF to reg 3, 0x55 to reg 4, carry=1.
- MUL started, start pulsed again at cycle 3 with opcode ADD -> ignored; exactly two saves (cycles 9, 10) with MUL results. Operands changed at cycle 2 -> results unchanged.
- reset=0 asserted asynchronously at cycle 4 of DIV -> busy/save/done drop immediately; no save ever seen; a new ADD after release completes normally in 1 cycle.
